// File: rtl/fetch_queue_stage.sv
// Decoupled fetch stage: issues PCs to a variable-latency imem, queues responses and feeds IF/ID.
// Define FETCH_PERF_CNT_EN to add saturating stall/flush/drop performance counters.
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int unsigned     AW      = $clog2(FQ_DEPTH);
  localparam int unsigned     CW      = AW + 1;
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FQ_DEPTH);
  localparam logic [CW-1:0]   FULL    = CW'(FQ_DEPTH);

  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [AW-1:0]   fq_head_q, fq_head_d, fq_tail_q, fq_tail_d;
  logic [AW-1:0]   sh_head_q, sh_head_d, sh_tail_q, sh_tail_d;
  logic [CW-1:0]   fq_count_q, fq_count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [XLEN-1:0] instrd_q, instrd_d, pcd_q, pcd_d, pcplus4d_q, pcplus4d_d;
  logic            validd_q, validd_d;

  logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0] fq_instr_q [FQ_DEPTH];
  logic [XLEN-1:0] sh_pc_q    [FQ_DEPTH];

  logic req_fire, rsp_drop, fq_push, fq_pop;

  // Occupancy counts both queued and in-flight entries, so the queue can never overflow.
  assign imem_req_valid = !rst && !PCSrcE &&
                          (({1'b0, fq_count_q} + {1'b0, outst_q}) < DEPTH_W);
  assign imem_req_addr  = pcf_q;
  assign InstrD         = instrd_q;
  assign PCD            = pcd_q;
  assign PCPlus4D       = pcplus4d_q;
  assign ValidD         = validd_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    req_fire   = imem_req_valid && imem_req_ready;
    rsp_drop   = imem_rsp_valid && (PCSrcE || (discard_q != '0));
    fq_push    = imem_rsp_valid && !rsp_drop;
    fq_pop     = !PCSrcE && !StallD && (fq_count_q != '0);

    outst_d    = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    sh_tail_d  = sh_tail_q + AW'(req_fire);
    sh_head_d  = sh_head_q + AW'(imem_rsp_valid);

    pcf_d      = pcf_q;
    fq_head_d  = fq_head_q;
    fq_tail_d  = fq_tail_q;
    fq_count_d = fq_count_q;
    discard_d  = discard_q;
    instrd_d   = instrd_q;
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    validd_d   = validd_q;

    if (PCSrcE) begin
      // Every request still unanswered after this edge belongs to the wrong path.
      pcf_d      = PCTargetE & ~XLEN'(3);
      fq_head_d  = '0;
      fq_tail_d  = '0;
      fq_count_d = '0;
      discard_d  = outst_d;
      instrd_d   = NOP;
      validd_d   = 1'b0;
    end else begin
      if (req_fire) pcf_d = pcf_q + XLEN'(4);
      if (imem_rsp_valid && (discard_q != '0)) discard_d = discard_q - CW'(1);
      fq_head_d  = fq_head_q + AW'(fq_pop);
      fq_tail_d  = fq_tail_q + AW'(fq_push);
      fq_count_d = fq_count_q + CW'(fq_push) - CW'(fq_pop);
      if (!StallD) begin
        if (fq_pop) begin
          instrd_d   = fq_instr_q[fq_head_q];
          pcd_d      = fq_pc_q[fq_head_q];
          pcplus4d_d = fq_pc_q[fq_head_q] + XLEN'(4);
          validd_d   = 1'b1;
        end else begin
          instrd_d   = NOP;
          validd_d   = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_q      <= RESET_PC;
      fq_head_q  <= '0;
      fq_tail_q  <= '0;
      fq_count_q <= '0;
      sh_head_q  <= '0;
      sh_tail_q  <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      instrd_q   <= NOP;
      pcd_q      <= '0;
      pcplus4d_q <= '0;
      validd_q   <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      fq_head_q  <= fq_head_d;
      fq_tail_q  <= fq_tail_d;
      fq_count_q <= fq_count_d;
      sh_head_q  <= sh_head_d;
      sh_tail_q  <= sh_tail_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      instrd_q   <= instrd_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      validd_q   <= validd_d;
    end
  end

  // NOTE: storage arrays are not reset; the pointers and counts alone define which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) sh_pc_q[sh_tail_q] <= pcf_q;
    if (fq_push) begin
      fq_pc_q[fq_tail_q]    <= sh_pc_q[sh_head_q];
      fq_instr_q[fq_tail_q] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (!validd_q && !StallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (PCSrcE && (flush_cnt_q != '1))               flush_cnt_d = flush_cnt_q + 32'd1;
    if (rsp_drop && (drop_cnt_q != '1))              drop_cnt_d  = drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`endif

  a_fq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fq_push |-> (fq_count_q != FULL));
  a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: imem model with variable latency plus a queue-level reference
// model of the fetch stream, compared on every falling edge, with directed literal checks.
module tb_fetch_queue_stage;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b0;
  logic        PCSrcE = 1'b0, StallD = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_drop_cnt;
`endif

  fetch_queue_stage #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
`ifdef FETCH_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_drop_cnt(perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'h1;
  endfunction

  // imem model: in-order responses, latency drawn from [lat_min, lat_max]
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    lat_min = 1, lat_max = 1;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: fetch PC, in-flight requests tagged for discard, queue, decode register
  typedef struct { logic [31:0] pc; bit drop; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } fq_t;
  infl_t       m_infl[$];
  fq_t         m_fq[$];
  logic [31:0] m_pcf, m_instr, m_pcd;
  bit          m_validd;
  logic [31:0] m_stall_cnt, m_flush_cnt, m_drop_cnt;

  always @(negedge clk) begin : compare
    bit    exp_rv, fire, got_rsp, drop_now;
    infl_t r;
    fq_t   h;
    int    due;
    if (rst) begin
      check("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      pend.delete();
      m_infl.delete();
      m_fq.delete();
      m_pcf = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_validd = 1'b0;
      m_stall_cnt = '0; m_flush_cnt = '0; m_drop_cnt = '0;
    end else begin
      exp_rv = (m_fq.size() + m_infl.size() < DEPTH) && !PCSrcE;
      check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) check("req_addr", imem_req_addr, m_pcf);
      check("ValidD", 32'(ValidD), 32'(m_validd));
      check("InstrD", InstrD, m_instr);
      if (m_validd) begin
        check("PCD", PCD, m_pcd);
        check("PCPlus4D", PCPlus4D, m_pcd + 32'd4);
      end
`ifdef FETCH_PERF_CNT_EN
      check("perf_stall", perf_stall_cnt, m_stall_cnt);
      check("perf_flush", perf_flush_cnt, m_flush_cnt);
      check("perf_drop", perf_drop_cnt, m_drop_cnt);
      if (!m_validd && !StallD) m_stall_cnt++;
      if (PCSrcE) m_flush_cnt++;
`endif
      // imem side follows the handshake actually presented by the design
      if (imem_rsp_valid) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (pend.size() > 0 && pend[$].due > due) due = pend[$].due;
        pend.push_back('{imem_req_addr, due});
      end

      fire    = exp_rv && imem_req_ready;
      got_rsp = 1'b0;
      if (imem_rsp_valid) begin
        check("rsp_has_request", 32'(m_infl.size() > 0), 32'd1);
        if (m_infl.size() > 0) begin
          r = m_infl.pop_front();
          got_rsp = 1'b1;
        end
      end
      drop_now = got_rsp && (PCSrcE || r.drop);
`ifdef FETCH_PERF_CNT_EN
      if (drop_now) m_drop_cnt++;
`endif
      if (PCSrcE) begin
        m_fq.delete();
        m_validd = 1'b0;
        m_instr  = NOP;
        m_pcf    = PCTargetE & ~32'h3;
        foreach (m_infl[i]) m_infl[i].drop = 1'b1;
      end else begin
        if (!StallD) begin
          if (m_fq.size() > 0) begin
            h = m_fq.pop_front();
            m_validd = 1'b1; m_instr = h.instr; m_pcd = h.pc;
          end else begin
            m_validd = 1'b0; m_instr = NOP;
          end
        end
        if (got_rsp && !drop_now) m_fq.push_back('{r.pc, mem_word(r.pc)});
        if (fire) begin
          m_infl.push_back('{m_pcf, 1'b0});
          m_pcf = m_pcf + 32'd4;
        end
      end
    end
  end

  // Inputs for the coming edge, applied just after the previous edge
  task automatic drive(input bit pcsrc, input logic [31:0] tgt, input bit stall, input bit rdy);
    PCSrcE = pcsrc; PCTargetE = tgt; StallD = stall; imem_req_ready = rdy;
    imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc + 1);
    imem_rsp_data  = imem_rsp_valid ? mem_word(pend[0].addr) : $urandom;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; PCSrcE = 1'b0; StallD = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    check("rst_ValidD", 32'(ValidD), 32'd0);
    check("rst_InstrD", InstrD, NOP);
    check("rst_PCD", PCD, 32'h0);
    check("rst_PCPlus4D", PCPlus4D, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    edge_step();
    edge_step();
    rst = 1'b0;
  endtask

  task automatic run_plain(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      edge_step();
    end
  endtask

  task automatic wait_for_pcd(input logic [31:0] pc, input int budget);
    for (int i = 0; i < budget && !(ValidD && PCD == pc); i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      edge_step();
    end
  endtask

  initial begin
    #2;
    // Sequential fetch, latency 1
    lat_min = 1; lat_max = 1;
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t1_addr0", imem_req_addr, 32'h0);
    check("t1_rv0", 32'(imem_req_valid), 32'd1);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t1_addr1", imem_req_addr, 32'h4);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t1_addr2", imem_req_addr, 32'h8);
    check("t1_not_yet_valid", 32'(ValidD), 32'd0);
    edge_step();
    check("t1_valid_edge3", 32'(ValidD), 32'd1);
    check("t1_pcd0", PCD, 32'h0);
    check("t1_instr0", InstrD, 32'h1);
    check("t1_pc4d0", PCPlus4D, 32'h4);
    run_plain(1);
    check("t1_pcd1", PCD, 32'h4);
    check("t1_instr1", InstrD, 32'h5);
    run_plain(1);
    check("t1_pcd2", PCD, 32'h8);
    check("t1_pc4d2", PCPlus4D, 32'hC);

    // Decode stall fills the queue and throttles requests
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      edge_step();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    check("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    check("t2_pcd_held", PCD, 32'h8);
    edge_step();
    run_plain(1);
    check("t2_resume_pcd", PCD, 32'hC);
    run_plain(8);

    // Redirect with two requests in flight, latency 3
    lat_min = 3; lat_max = 3;
    do_reset();
    run_plain(2);
    drive(1'b1, 32'h0000_0103, 1'b0, 1'b1);
    check("t3_rv_redirect", 32'(imem_req_valid), 32'd0);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t3_target_addr", imem_req_addr, 32'h100);
    check("t3_target_rv", 32'(imem_req_valid), 32'd1);
    edge_step();
    wait_for_pcd(32'h100, 20);
    check("t3_first_valid", 32'(ValidD), 32'd1);
    check("t3_first_pcd", PCD, 32'h100);
    check("t3_first_instr", InstrD, 32'h101);

    // Redirect in the cycle a response arrives, with a later reply still owed
    lat_min = 2; lat_max = 2;
    do_reset();
    run_plain(2);
    drive(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    edge_step();
    check("t4_bubble0", 32'(ValidD), 32'd0);
    run_plain(1);
    check("t4_bubble1", 32'(ValidD), 32'd0);
    wait_for_pcd(32'h200, 20);
    check("t4_first_pcd", PCD, 32'h200);

    // Reset mid-stream with three requests outstanding
    lat_min = 3; lat_max = 3;
    run_plain(4);
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t5_restart_addr", imem_req_addr, 32'h0);
    edge_step();
    wait_for_pcd(32'h0, 20);
    check("t5_first_pcd", PCD, 32'h0);
    check("t5_first_instr", InstrD, 32'h1);

    // PC wrap-around
    lat_min = 1; lat_max = 1;
    drive(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_addr0", imem_req_addr, 32'hFFFF_FFF8);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_addr1", imem_req_addr, 32'hFFFF_FFFC);
    edge_step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("t6_addr2", imem_req_addr, 32'h0);
    edge_step();
    wait_for_pcd(32'hFFFF_FFFC, 10);
    check("t6_pcd", PCD, 32'hFFFF_FFFC);
    check("t6_pc4d_wrap", PCPlus4D, 32'h0);

    // Randomised traffic: stalls, backpressure, redirects, variable latency
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 7);
      edge_step();
    end
    run_plain(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
